ram_loader: RTL and testbench
=============================

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-005 baseAddr  input  8  first RAM address of the load; latched on accepted start.
REQ-006 inValid  input  1  upstream byte present on inData.
REQ-007 inData  input  8  upstream byte (length, payload, checksum).
REQ-008 inReady  output  1  loader accepts inData this cycle; a transfer occurs when inValid and inReady are both high.
REQ-009 ramAddr  output  8  RAM address, registered.
REQ-010 ramDataIn  output  8  RAM write data, registered.
REQ-011 ramWriteEnable  output  1  RAM write strobe, registered, one cycle per byte.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse at load completion.
REQ-014 error  output  1  sticky checksum-mismatch flag.

Function
REQ-015 The state machine SHALL have states IDLE, LEN, LOAD, CSUM (CSUM exists only when configured) and DONE.
REQ-016 IDLE: start high -> LEN next cycle; baseAddr latched into the address counter; error cleared; byte counter and checksum accumulator cleared.
REQ-017 inReady SHALL be high in LEN, LOAD and CSUM, and low in IDLE and DONE.
REQ-018 LEN: first transfer latches length N; N=0 means 256 bytes; -> LOAD.
REQ-019 LOAD: each transfer at cycle k SHALL produce ramWriteEnable=1, ramAddr=current address, ramDataIn=byte at cycle k+1 (latency one cycle), sustaining one byte per cycle.
REQ-020 The address counter SHALL increment by one per payload byte modulo 256 (0xFF wraps to 0x00).
REQ-021 After the N-th payload transfer the machine SHALL go to CSUM if configured, else DONE.
REQ-022 Cycles with inValid low SHALL stall without writing and without changing counters.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; the final payload write SHALL coincide with the DONE cycle.
REQ-024 start asserted while busy SHALL be ignored.
REQ-025 ramWriteEnable SHALL be low in every cycle not immediately following a payload transfer.

Reset
REQ-026 On reset the state SHALL be IDLE and ramAddr=0x00, ramDataIn=0x00, ramWriteEnable=0, inReady=0, busy=0, done=0, error=0.
REQ-027 Reset asserted mid-load SHALL abort at the next edge; a write pending from the prior transfer SHALL be dropped; RAM contents already written are unaffected.

Configuration
REQ-028 Macro RAM_LOADER_CHECKSUM_EN defined: the accumulator sums payload bytes modulo 256; CSUM accepts one byte; a mismatch sets error (held until next accepted start or reset); done pulses regardless of match.
REQ-029 Macro RAM_LOADER_CHECKSUM_EN undefined: no CSUM state, no checksum byte consumed, error tied to 0.

Verification
REQ-030 baseAddr=0x10, start, stream 0x03,0xAA,0xBB,0xCC with inValid constant -> writes 0x10=0xAA, 0x11=0xBB, 0x12=0xCC on consecutive cycles; done one cycle; busy low afterwards.
REQ-031 baseAddr=0xFE, length 0x03, payload 0x01,0x02,0x03 -> writes at 0xFE, 0xFF, 0x00 (wrap).
REQ-032 Length 0x00 with 256 payload bytes from baseAddr=0x00 -> exactly 256 writes covering 0x00-0xFF, then done.
REQ-033 Payload 0x11,0x22 with inValid low for 3 cycles between them -> no ramWriteEnable during the gap; both bytes written to consecutive addresses.
REQ-034 With RAM_LOADER_CHECKSUM_EN: payload 0x10,0x20 plus checksum 0x30 -> error=0; with checksum 0x31 -> error=1 after done, cleared by next start.
REQ-035 Reset asserted the cycle after the second payload byte of a 4-byte load -> that byte not written; outputs at reset values; new start loads normally.

Source files
------------

// File: rtl/ram_loader.sv
// Streams a length-prefixed byte packet into RAM from a latched base address.
// Optional trailing checksum byte is checked when RAM_LOADER_CHECKSUM_EN is defined.
module ram_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] baseAddr,
    input  logic       inValid,
    input  logic [7:0] inData,
    output logic       inReady,
    output logic [7:0] ramAddr,
    output logic [7:0] ramDataIn,
    output logic       ramWriteEnable,
    output logic       busy,
    output logic       done,
    output logic       error
);

`ifdef RAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_LOAD, S_CSUM, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_LOAD, S_DONE} state_t;
`endif

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_addr;
    logic [7:0] r_len;
    logic [7:0] r_cnt;
    logic       r_vld_p1;
    logic [7:0] r_waddr_p1;
    logic [7:0] r_wdata_p1;
    logic [7:0] w_len_m1;
    logic       w_last;

    // A stored length of 0 wraps to 0xFF here, giving a 256-byte packet.
    assign w_len_m1 = r_len - 8'd1;
    assign w_last   = (r_cnt == w_len_m1);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        inReady = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_LEN;
            end
            S_LEN: begin
                inReady = 1'b1;
                if (inValid) w_next = S_LOAD;
            end
            S_LOAD: begin
                inReady = 1'b1;
`ifdef RAM_LOADER_CHECKSUM_EN
                if (inValid && w_last) w_next = S_CSUM;
`else
                if (inValid && w_last) w_next = S_DONE;
`endif
            end
`ifdef RAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                inReady = 1'b1;
                if (inValid) w_next = S_DONE;
            end
`endif
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

`ifdef RAM_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum <= 8'h00;
            r_err <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_sum <= 8'h00;
            r_err <= 1'b0;
        end else if (r_state == S_LOAD && inValid) begin
            r_sum <= r_sum + inData;
        end else if (r_state == S_CSUM && inValid && inData != r_sum) begin
            r_err <= 1'b1;
        end
    end

    assign error = r_err;
`else
    assign error = 1'b0;
`endif

    // ---- stage p0 -> p1: accepted payload byte becomes a registered RAM write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= 8'h00;
            r_len      <= 8'h00;
            r_cnt      <= 8'h00;
            r_vld_p1   <= 1'b0;
            r_waddr_p1 <= 8'h00;
            r_wdata_p1 <= 8'h00;
        end else begin
            r_vld_p1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr <= baseAddr;
                        r_cnt  <= 8'h00;
                    end
                end
                S_LEN: begin
                    if (inValid) r_len <= inData;
                end
                S_LOAD: begin
                    if (inValid) begin
                        r_vld_p1   <= 1'b1;
                        r_waddr_p1 <= r_addr;
                        r_wdata_p1 <= inData;
                        r_addr     <= r_addr + 8'd1;
                        r_cnt      <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ramAddr   = r_waddr_p1;
    assign ramDataIn = r_wdata_p1;
    // Reset kills a write still sitting in the output register so an aborted
    // load never lands its in-flight byte.
    assign ramWriteEnable = r_vld_p1 & ~reset;

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: expected RAM writes are queued as payload
// bytes are driven and matched against the write strobe as it appears.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] baseAddr = 8'h00;
    logic       inValid = 1'b0;
    logic [7:0] inData = 8'h00;
    logic       inReady;
    logic [7:0] ramAddr;
    logic [7:0] ramDataIn;
    logic       ramWriteEnable;
    logic       busy;
    logic       done;
    logic       error;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  pay[256];

    ram_loader dut (
        .clk(clk), .reset(reset), .start(start), .baseAddr(baseAddr),
        .inValid(inValid), .inData(inData), .inReady(inReady),
        .ramAddr(ramAddr), .ramDataIn(ramDataIn), .ramWriteEnable(ramWriteEnable),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ramWriteEnable === 1'b1) begin
            logic [15:0] e;
            wr_count++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write_addr", {24'h0, ramAddr}, 32'h100);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_addr", {24'h0, ramAddr}, {24'h0, e[15:8]});
                check_eq("wr_data", {24'h0, ramDataIn}, {24'h0, e[7:0]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] base, input int n, input bit gap, input bit bad);
        logic [7:0] sum;
        logic [7:0] lenb;
        int wc_start;
        int wc_gap;
        wc_start = wr_count;
        sum = 8'h00;
        lenb = n[7:0];
        baseAddr = base;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("len_busy", {31'h0, busy}, 32'h1);
        check_eq("len_ready", {31'h0, inReady}, 32'h1);
        check_eq("err_clr_on_start", {31'h0, error}, 32'h0);
        inValid = 1'b1;
        inData = lenb;
        tick();
        for (int i = 0; i < n; i++) begin
            logic [7:0] a;
            a = base + i[7:0];
            inData = pay[i];
            inValid = 1'b1;
            exp_q.push_back({a, pay[i]});
            sum = sum + pay[i];
            tick();
            if (gap && i == 0) begin
                wc_gap = wr_count;
                inValid = 1'b0;
                start = 1'b1;
                baseAddr = 8'h77;
                tick();
                start = 1'b0;
                tick();
                tick();
                check_eq("gap_writes", wr_count - wc_gap, 32'd1);
            end
        end
        inValid = 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
        inValid = 1'b1;
        inData = bad ? (sum ^ 8'h01) : sum;
        tick();
        inValid = 1'b0;
`endif
        check_eq("done_pulse", {31'h0, done}, 32'h1);
        check_eq("done_ready_low", {31'h0, inReady}, 32'h0);
`ifdef RAM_LOADER_CHECKSUM_EN
        check_eq("csum_error", {31'h0, error}, {31'h0, bad});
`else
        check_eq("error_tied", {31'h0, error}, 32'h0);
`endif
        tick();
        check_eq("done_cleared", {31'h0, done}, 32'h0);
        check_eq("idle_busy", {31'h0, busy}, 32'h0);
        check_eq("write_count", wr_count - wc_start, n);
        check_eq("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        check_eq("rst_addr", {24'h0, ramAddr}, 32'h0);
        check_eq("rst_data", {24'h0, ramDataIn}, 32'h0);
        check_eq("rst_we", {31'h0, ramWriteEnable}, 32'h0);
        check_eq("rst_ready", {31'h0, inReady}, 32'h0);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_done", {31'h0, done}, 32'h0);
        check_eq("rst_error", {31'h0, error}, 32'h0);
        reset = 1'b0;
        tick();

        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
        do_load(8'h10, 3, 1'b0, 1'b0);

        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
        do_load(8'hFE, 3, 1'b0, 1'b0);

        for (int i = 0; i < 256; i++) pay[i] = i[7:0] ^ 8'h5A;
        do_load(8'h00, 256, 1'b0, 1'b0);

        pay[0] = 8'h11; pay[1] = 8'h22;
        do_load(8'h30, 2, 1'b1, 1'b0);

        pay[0] = 8'h10; pay[1] = 8'h20;
        do_load(8'h50, 2, 1'b0, 1'b0);
        do_load(8'h50, 2, 1'b0, 1'b1);
        do_load(8'h60, 2, 1'b0, 1'b0);

        // Abort a 4-byte load right after its second payload byte is taken.
        baseAddr = 8'h40;
        start = 1'b1;
        tick();
        start = 1'b0;
        inValid = 1'b1;
        inData = 8'h04;
        tick();
        inData = 8'h5A;
        exp_q.push_back({8'h40, 8'h5A});
        tick();
        inData = 8'h6B;
        tick();
        reset = 1'b1;
        inValid = 1'b0;
        #1;
        check_eq("abort_we_dropped", {31'h0, ramWriteEnable}, 32'h0);
        tick();
        check_eq("abort_addr", {24'h0, ramAddr}, 32'h0);
        check_eq("abort_data", {24'h0, ramDataIn}, 32'h0);
        check_eq("abort_we", {31'h0, ramWriteEnable}, 32'h0);
        check_eq("abort_ready", {31'h0, inReady}, 32'h0);
        check_eq("abort_busy", {31'h0, busy}, 32'h0);
        check_eq("abort_done", {31'h0, done}, 32'h0);
        check_eq("abort_error", {31'h0, error}, 32'h0);
        reset = 1'b0;
        tick();
        check_eq("abort_queue", exp_q.size(), 32'd0);

        pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE; pay[3] = 8'hEF;
        do_load(8'h40, 4, 1'b0, 1'b0);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
